// File: rtl/timer_pkg.sv
// Timer shared definitions: register map,
// control/status bit positions, FSM states.
package timer_pkg;

  localparam logic [4:0] REG_CTRL    = 5'd0;
  localparam logic [4:0] REG_PRESC   = 5'd1;
  localparam logic [4:0] REG_COMPARE = 5'd2;
  localparam logic [4:0] REG_COUNT   = 5'd3;
  localparam logic [4:0] REG_STATUS  = 5'd4;
  localparam logic [4:0] REG_CAPTURE = 5'd5;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_AR  = 1;
  localparam int CTRL_IE  = 2;

  localparam int ST_MATCH = 0;
  localparam int ST_CAP   = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Timer prescaler: counts 0..limit and pulses
// tick for one cycle when it reaches limit.
module timer_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = en && !clr && (cnt == limit);

  // Free-running divider, restarted by clear, idle or tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_top.sv
// Prescaled compare timer with slot register interface.
// Optional input capture block enabled by TIMER_CAPTURE_EN.
module timer_top
  import timer_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        capture_in,
  output logic        irq
);

  state_t state, state_d;

  logic                  ctrl_ar;
  logic                  ctrl_ie;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0]           compare;
  logic [31:0]           count;
  logic [1:0]            status;
  logic [31:0]           capture;
  logic                  cap_edge;

  logic wr;
  logic wr_ctrl, wr_presc, wr_cmp;
  logic wr_cnt, wr_stat;
  logic tick;
  logic match_hit;
  logic [1:0] st_set, st_clr;
  logic [31:0] rd_mux;

  assign wr       = cs && write;
  assign wr_ctrl  = wr && (addr == REG_CTRL);
  assign wr_presc = wr && (addr == REG_PRESC);
  assign wr_cmp   = wr && (addr == REG_COMPARE);
  assign wr_cnt   = wr && (addr == REG_COUNT);
  assign wr_stat  = wr && (addr == REG_STATUS);

  timer_prescaler #(
    .W(PRESCALE_W)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (state == S_RUN),
    .clr   (wr_ctrl || wr_presc),
    .limit (prescale),
    .tick  (tick)
  );

  assign match_hit = tick && (count == compare);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next state: CTRL writes dominate, match ends one-shot runs.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (wr_ctrl && wr_data[CTRL_EN]) state_d = S_RUN;
      end
      S_RUN: begin
        if (wr_ctrl) begin
          state_d = wr_data[CTRL_EN] ? S_RUN : S_IDLE;
        end else if (match_hit && !ctrl_ar) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (wr_ctrl) begin
          state_d = wr_data[CTRL_EN] ? S_RUN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Configuration registers written from the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_ar  <= 1'b0;
      ctrl_ie  <= 1'b0;
      prescale <= '0;
      compare  <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_ar <= wr_data[CTRL_AR];
        ctrl_ie <= wr_data[CTRL_IE];
      end
      if (wr_presc) prescale <= wr_data[PRESCALE_W-1:0];
      if (wr_cmp)   compare  <= wr_data;
    end
  end

  // Main counter: slot write beats a tick in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (wr_cnt) begin
      count <= wr_data;
    end else if (tick) begin
      if (match_hit) begin
        if (ctrl_ar) count <= '0;
      end else begin
        count <= count + 32'd1;
      end
    end
  end

  assign st_set = {cap_edge, match_hit};
  assign st_clr = wr_stat ? wr_data[1:0] : 2'b00;

  // Sticky status, write-one-to-clear; hardware set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status <= 2'b00;
    end else begin
      status <= (status & ~st_clr) | st_set;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic cap_s1, cap_s2, cap_s3;

  assign cap_edge = cap_s2 && !cap_s3;

  // Synchronise capture_in, keep one history flop for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_s1 <= 1'b0;
      cap_s2 <= 1'b0;
      cap_s3 <= 1'b0;
    end else begin
      cap_s1 <= capture_in;
      cap_s2 <= cap_s1;
      cap_s3 <= cap_s2;
    end
  end

  // Snapshot COUNT on a synchronised rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      capture <= '0;
    end else if (cap_edge) begin
      capture <= count;
    end
  end
`else
  logic unused_capture_in;

  assign unused_capture_in = capture_in;
  assign cap_edge          = 1'b0;
  assign capture           = '0;
`endif

  assign irq = (status[ST_MATCH] || status[ST_CAP]) && ctrl_ie;

  // Read mux, side-effect free.
  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_CTRL: begin
        rd_mux[CTRL_EN] = (state == S_RUN);
        rd_mux[CTRL_AR] = ctrl_ar;
        rd_mux[CTRL_IE] = ctrl_ie;
      end
      REG_PRESC:   rd_mux = 32'(prescale);
      REG_COMPARE: rd_mux = compare;
      REG_COUNT:   rd_mux = count;
      REG_STATUS:  rd_mux[1:0] = status;
      REG_CAPTURE: rd_mux = capture;
      default:     rd_mux = '0;
    endcase
  end

  assign rd_data = (cs && read) ? rd_mux : '0;

endmodule

// File: tb/tb_timer_top.sv
// Directed testbench for timer_top.
// Capture scenario built only with TIMER_CAPTURE_EN.
module tb_timer_top;
  import timer_pkg::*;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        capture_in;
  logic        irq;

  int total;
  int bad;

  timer_top #(
    .PRESCALE_W(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .capture_in (capture_in),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1;
    write = 1'b1;
    addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0;
    write = 1'b0;
    wr_data = '0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1;
    read = 1'b1;
    addr = a;
    #1;
    d = rd_data;
    cs = 1'b0;
    read = 1'b0;
  endtask

  task automatic do_reset();
    cs = 1'b0;
    read = 1'b0;
    write = 1'b0;
    capture_in = 1'b0;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    for (int a = 0; a < 8; a++) begin
      rd(5'(a), v);
      total++;
      if (v !== 32'd0) begin
        bad++;
        $display("FAIL rst_reg%0d got=%0h exp=0", a, v);
      end
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL rst_irq got=%b exp=0", irq);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    do_reset();
    wr(REG_PRESC, 32'd0);
    wr(REG_COMPARE, 32'd3);
    wr(REG_CTRL, 32'h7);
    step(3);
    rd(REG_COUNT, v);
    total++;
    if (v !== 32'd3) begin
      bad++;
      $display("FAIL ar_cnt3 got=%0h exp=3", v);
    end
    rd(REG_STATUS, v);
    total++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL ar_pre_match st=%0h irq=%b exp=0/0", v, irq);
    end
    step(1);
    rd(REG_STATUS, v);
    total++;
    if (v !== 32'd1 || irq !== 1'b1) begin
      bad++;
      $display("FAIL ar_match st=%0h irq=%b exp=1/1", v, irq);
    end
    rd(REG_COUNT, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL ar_reload got=%0h exp=0", v);
    end
    step(2);
    rd(REG_COUNT, v);
    total++;
    if (v !== 32'd2) begin
      bad++;
      $display("FAIL ar_continue got=%0h exp=2", v);
    end
    rd(REG_CTRL, v);
    total++;
    if (v !== 32'h7) begin
      bad++;
      $display("FAIL ar_ctrl got=%0h exp=7", v);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    wr(REG_PRESC, 32'd4);
    wr(REG_COMPARE, 32'd1);
    wr(REG_CTRL, 32'h1);
    rd(REG_PRESC, v);
    total++;
    if (v !== 32'd4) begin
      bad++;
      $display("FAIL os_presc got=%0h exp=4", v);
    end
    step(4);
    rd(REG_COUNT, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL os_no_tick got=%0h exp=0", v);
    end
    step(1);
    rd(REG_COUNT, v);
    total++;
    if (v !== 32'd1) begin
      bad++;
      $display("FAIL os_tick1 got=%0h exp=1", v);
    end
    rd(REG_CTRL, v);
    total++;
    if (v !== 32'h1) begin
      bad++;
      $display("FAIL os_run_en got=%0h exp=1", v);
    end
    step(4);
    rd(REG_STATUS, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL os_early got=%0h exp=0", v);
    end
    step(1);
    rd(REG_STATUS, v);
    total++;
    if (v !== 32'd1) begin
      bad++;
      $display("FAIL os_match got=%0h exp=1", v);
    end
    rd(REG_CTRL, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL os_done_en got=%0h exp=0", v);
    end
    step(7);
    rd(REG_COUNT, v);
    total++;
    if (v !== 32'd1) begin
      bad++;
      $display("FAIL os_hold got=%0h exp=1", v);
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL os_irq got=%b exp=0", irq);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    do_reset();
    wr(REG_COUNT, 32'hFFFF_FFFF);
    wr(REG_COMPARE, 32'd5);
    wr(REG_PRESC, 32'd0);
    rd(REG_COUNT, v);
    total++;
    if (v !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL wrap_load got=%0h exp=ffffffff", v);
    end
    wr(REG_CTRL, 32'h1);
    step(1);
    rd(REG_COUNT, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL wrap_zero got=%0h exp=0", v);
    end
  endtask

  task automatic test_count_priority();
    logic [31:0] v;
    do_reset();
    wr(REG_PRESC, 32'd0);
    wr(REG_COMPARE, 32'd1000);
    wr(REG_CTRL, 32'h1);
    step(2);
    wr(REG_COUNT, 32'd100);
    rd(REG_COUNT, v);
    total++;
    if (v !== 32'd100) begin
      bad++;
      $display("FAIL prio_write got=%0h exp=64", v);
    end
    step(1);
    rd(REG_COUNT, v);
    total++;
    if (v !== 32'd101) begin
      bad++;
      $display("FAIL prio_next got=%0h exp=65", v);
    end
  endtask

  task automatic test_w1c();
    logic [31:0] v;
    do_reset();
    wr(REG_PRESC, 32'd0);
    wr(REG_COMPARE, 32'd3);
    wr(REG_CTRL, 32'h7);
    step(3);
    wr(REG_STATUS, 32'h1);
    rd(REG_STATUS, v);
    total++;
    if (v !== 32'd1 || irq !== 1'b1) begin
      bad++;
      $display("FAIL w1c_same st=%0h irq=%b exp=1/1", v, irq);
    end
    wr(REG_STATUS, 32'h1);
    rd(REG_STATUS, v);
    total++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL w1c_later st=%0h irq=%b exp=0/0", v, irq);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    do_reset();
    wr(REG_PRESC, 32'd0);
    wr(REG_COMPARE, 32'd2);
    wr(REG_CTRL, 32'h7);
    step(4);
    reset = 1'b0;
    #1;
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL ar_irq got=%b exp=0", irq);
    end
    for (int a = 0; a < 6; a++) begin
      rd(5'(a), v);
      total++;
      if (v !== 32'd0) begin
        bad++;
        $display("FAIL arst_reg%0d got=%0h exp=0", a, v);
      end
    end
    step(1);
    reset = 1'b1;
    step(5);
    rd(REG_COUNT, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL arst_nocount got=%0h exp=0", v);
    end
    rd(REG_CTRL, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL arst_ctrl got=%0h exp=0", v);
    end
  endtask

`ifdef TIMER_CAPTURE_EN
  task automatic test_capture();
    logic [31:0] v;
    do_reset();
    wr(REG_PRESC, 32'd0);
    wr(REG_COMPARE, 32'd1000);
    wr(REG_CTRL, 32'h5);
    step(8);
    capture_in = 1'b1;
    step(2);
    rd(REG_STATUS, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL cap_early got=%0h exp=0", v);
    end
    step(1);
    rd(REG_CAPTURE, v);
    total++;
    if (v !== 32'd10) begin
      bad++;
      $display("FAIL cap_value got=%0h exp=a", v);
    end
    rd(REG_STATUS, v);
    total++;
    if (v !== 32'd2 || irq !== 1'b1) begin
      bad++;
      $display("FAIL cap_flag st=%0h irq=%b exp=2/1", v, irq);
    end
    step(3);
    rd(REG_CAPTURE, v);
    total++;
    if (v !== 32'd10) begin
      bad++;
      $display("FAIL cap_hold got=%0h exp=a", v);
    end
  endtask
`else
  task automatic test_capture();
    logic [31:0] v;
    do_reset();
    wr(REG_PRESC, 32'd0);
    wr(REG_COMPARE, 32'd1000);
    wr(REG_CTRL, 32'h5);
    step(3);
    capture_in = 1'b1;
    step(5);
    rd(REG_CAPTURE, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL nocap_value got=%0h exp=0", v);
    end
    rd(REG_STATUS, v);
    total++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL nocap_flag st=%0h irq=%b exp=0/0", v, irq);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    cs = 1'b0;
    read = 1'b0;
    write = 1'b0;
    addr = '0;
    wr_data = '0;
    capture_in = 1'b0;
    step(2);
    test_reset();
    reset = 1'b1;
    step(1);
    test_autoreload();
    test_oneshot();
    test_wrap();
    test_count_priority();
    test_w1c();
    test_async_reset();
    test_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
